// File: rtl/midori_pkg.sv
// Shared constants and types for the Midori SubCell engine: S-box tables,
// SSb bit-position permutations, mode encoding and FSM state type.
package midori_pkg;

  // Nibble tables: entry i is held at bits [4i+3:4i].
  localparam logic [63:0] SB0 = 64'h6420_5198_7fbe_3dac;
  localparam logic [63:0] SB1 = 64'h648c_b9ad_7f2e_3501;

  localparam logic [2:0] SSB_IN_PERM [4][8] = '{
    '{3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7},
    '{3'd1, 3'd6, 3'd7, 3'd0, 3'd5, 3'd2, 3'd3, 3'd4},
    '{3'd2, 3'd3, 3'd4, 3'd1, 3'd6, 3'd7, 3'd0, 3'd5},
    '{3'd7, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6}
  };

  localparam logic [2:0] SSB_OUT_PERM [4][8] = '{
    '{3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7},
    '{3'd3, 3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd1, 3'd2},
    '{3'd6, 3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd5},
    '{3'd5, 3'd2, 3'd3, 3'd4, 3'd1, 3'd6, 3'd7, 3'd0}
  };

  localparam logic MODE_M128 = 1'b0;
  localparam logic MODE_M64  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] sb_lookup(input logic [63:0] tbl, input logic [3:0] n);
    return tbl[{n, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/midori_ssb_lane.sv
// One byte lane of the SubCell layer: SSb_k (Midori-128) or a pair of Sb0
// nibble lookups (Midori-64). Purely combinational.
module midori_ssb_lane
  import midori_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic [1:0] k,
  input  logic       mode,
  output logic [7:0] byte_out
);

  logic [3:0] hi;
  logic [3:0] lo;
  logic [7:0] t;

  // Position p of a byte is bit 7-p; gathered bits are packed MSB-first.
  always_comb begin
    hi       = '0;
    lo       = '0;
    t        = '0;
    byte_out = '0;
    for (int j = 0; j < 4; j++) begin
      hi[2'(3 - j)] = byte_in[3'd7 - SSB_IN_PERM[k][3'(j)]];
      lo[2'(3 - j)] = byte_in[3'd7 - SSB_IN_PERM[k][3'(j + 4)]];
    end
    t = {sb_lookup(SB1, hi), sb_lookup(SB1, lo)};
    if (mode == MODE_M64) begin
      byte_out = {sb_lookup(SB0, byte_in[7:4]), sb_lookup(SB0, byte_in[3:0])};
    end else begin
      for (int j = 0; j < 8; j++) begin
        byte_out[3'(7 - j)] = t[3'd7 - SSB_OUT_PERM[k][3'(j)]];
      end
    end
  end

endmodule

// File: rtl/midori_sub_cell_serial.sv
// Iterative Midori SubCell engine: substitutes LANES bytes per beat in place,
// with valid/ready handshakes on input and output.
//
//   state | meaning
//   IDLE  | ready for a block; in_ready high
//   BUSY  | one beat per cycle, LANES bytes substituted in place
//   DONE  | result presented on out_state until out_ready (or abort)
module midori_sub_cell_serial
  import midori_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_state,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int         LOG_L    = $clog2(LANES);
  localparam logic [3:0] LAST_128 = 4'(16 / LANES - 1);
  localparam logic [3:0] LAST_64  = 4'((LANES >= 8) ? 0 : (8 / LANES - 1));

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("midori_sub_cell_serial: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t        fsm_q, fsm_d;
  logic          mode_q, mode_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  blk_q, blk_d;
  logic [3:0]    last_beat;

  logic [3:0]    lane_idx [LANES];
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  // Lane l handles byte cnt*LANES + l; the shift wraps to 0 when LANES=16.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = (cnt_q << LOG_L) + 4'(l);
      lane_in[l]  = blk_q[{lane_idx[l], 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    midori_ssb_lane u_lane (
      .byte_in  (lane_in[g]),
      .k        (lane_idx[g][1:0]),
      .mode     (mode_q),
      .byte_out (lane_out[g])
    );
  end

  assign last_beat = (mode_q == MODE_M64) ? LAST_64 : LAST_128;

  always_comb begin
    fsm_d  = fsm_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    blk_d  = blk_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && !abort) begin
          fsm_d  = ST_BUSY;
          mode_d = in_mode;
          cnt_d  = '0;
          blk_d  = (in_mode == MODE_M64) ? {64'd0, in_state[63:0]} : in_state;
        end
      end
      ST_BUSY: begin
        if (abort) begin
          fsm_d = ST_IDLE;
          cnt_d = '0;
          blk_d = '0;
        end else begin
          // Upper-half lanes stay untouched in Midori-64 (only reachable at LANES=16).
          for (int l = 0; l < LANES; l++) begin
            if (!(mode_q == MODE_M64 && lane_idx[l][3])) begin
              blk_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
            end
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == last_beat) begin
            fsm_d = ST_DONE;
            cnt_d = '0;
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          fsm_d = ST_IDLE;
          blk_d = '0;
        end else if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
        cnt_d = '0;
        blk_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      mode_q <= MODE_M128;
      cnt_q  <= '0;
      blk_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_BUSY) || (fsm_q == ST_DONE);
  assign out_state = (fsm_q == ST_DONE) ? blk_q : '0;

endmodule

// File: tb/tb_midori_sub_cell_serial.sv
// Self-checking bench: one engine per legal LANES value, compared against a
// whole-block behavioural model of the Midori SubCell layer.
module tb_midori_sub_cell_serial;

  localparam int ND = 5;
  localparam int LV [ND] = '{1, 2, 4, 8, 16};
  localparam int MAIN = 2;  // LANES=4 instance

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_mode = 1'b0;
  logic [127:0] in_state = '0;
  logic         abort = 1'b0;
  logic [ND-1:0] in_valid_v = '0;
  logic [ND-1:0] out_ready_v = '0;
  logic [ND-1:0] in_ready_v;
  logic [ND-1:0] out_valid_v;
  logic [ND-1:0] busy_v;
  logic [127:0]  out_state_v [ND];

  int checks = 0;
  int failures = 0;

  int sb0_t [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
  int sb1_t [16] = '{1, 0, 5, 3, 14, 2, 15, 7, 13, 10, 9, 11, 12, 8, 4, 6};
  int inp [4][8] = '{'{4,1,6,3,0,5,2,7}, '{1,6,7,0,5,2,3,4}, '{2,3,4,1,6,7,0,5}, '{7,4,1,2,3,0,5,6}};
  int outp [4][8] = '{'{4,1,6,3,0,5,2,7}, '{3,0,5,6,7,4,1,2}, '{6,3,0,1,2,7,4,5}, '{5,2,3,4,1,6,7,0}};

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    midori_sub_cell_serial #(.LANES(LV[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_mode   (in_mode),
      .in_state  (in_state),
      .abort     (abort),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_state (out_state_v[g]),
      .busy      (busy_v[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic m, input logic [127:0] x);
    logic [127:0] r;
    int b, h, l, t, y, k;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = int'(x[i*8 +: 8]);
      y = 0;
      if (m) begin
        if (i < 8) y = sb0_t[b / 16] * 16 + sb0_t[b % 16];
      end else begin
        k = i % 4;
        h = 0;
        l = 0;
        for (int j = 0; j < 4; j++) begin
          h = h * 2 + ((b >> (7 - inp[k][j])) & 1);
          l = l * 2 + ((b >> (7 - inp[k][j + 4])) & 1);
        end
        t = sb1_t[h] * 16 + sb1_t[l];
        for (int j = 0; j < 8; j++) y = y * 2 + ((t >> (7 - outp[k][j])) & 1);
      end
      r[i*8 +: 8] = 8'(y);
    end
    return r;
  endfunction

  function automatic int nbeats(input int lanes, input logic m);
    if (m) return (8 / lanes > 1) ? 8 / lanes : 1;
    return 16 / lanes;
  endfunction

  task automatic wait_out(input int d, output int cyc);
    cyc = 0;
    while (!out_valid_v[d] && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid_v[d]) chk("out_valid_timeout", 128'(out_valid_v[d]), 128'(1));
  endtask

  // Accept one block, wait for the result, then consume it. lat counts cycles from accept.
  task automatic run_block(input int d, input logic m, input logic [127:0] x,
                           output logic [127:0] y, output int lat);
    int c;
    in_mode = m;
    in_state = x;
    in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    wait_out(d, c);
    lat = c + 1;
    y = out_state_v[d];
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x, x2, y1, y2, xm, ref_y;
    int lat, c;
    logic seen;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready_v[MAIN]), 128'(1));
    chk("rst_out_valid", 128'(out_valid_v[MAIN]), 128'(0));
    chk("rst_busy", 128'(busy_v[MAIN]), 128'(0));
    chk("rst_out_state", out_state_v[MAIN], 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_block(MAIN, 1'b0, '0, y1, lat);
    chk("zero_m128", y1, 128'h22448811_22448811_22448811_22448811);
    chk("zero_m128_lat", 128'(lat), 128'(5));

    run_block(MAIN, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, y1, lat);
    chk("zero_m64", y1, 128'h0000000000000000_CCCCCCCCCCCCCCCC);
    chk("zero_m64_lat", 128'(lat), 128'(3));

    for (int d = 0; d < ND; d++) begin
      for (int mi = 0; mi < 2; mi++) begin
        for (int rep = 0; rep < 2; rep++) begin
          x = {$urandom, $urandom, $urandom, $urandom};
          xm = (mi == 1) ? {64'd0, x[63:0]} : x;
          run_block(d, 1'(mi), x, y1, lat);
          chk($sformatf("sub_l%0d_m%0d", LV[d], mi), y1, model(1'(mi), x));
          chk($sformatf("lat_l%0d_m%0d", LV[d], mi), 128'(lat), 128'(nbeats(LV[d], 1'(mi)) + 1));
          run_block(d, 1'(mi), y1, y2, lat);
          chk($sformatf("invol_l%0d_m%0d", LV[d], mi), y2, xm);
        end
      end
    end

    // Backpressure: result held, input ignored while DONE, one accept after release.
    x = {$urandom, $urandom, $urandom, $urandom};
    x2 = {$urandom, $urandom, $urandom, $urandom};
    ref_y = model(1'b0, x);
    in_mode = 1'b0;
    in_state = x;
    in_valid_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    in_state = x2;
    wait_out(MAIN, c);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_state", out_state_v[MAIN], ref_y);
      chk("bp_in_ready", 128'(in_ready_v[MAIN]), 128'(0));
      @(posedge clk); #1;
    end
    out_ready_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[MAIN] = 1'b0;
    chk("bp_handoff_idle", 128'(in_ready_v[MAIN]), 128'(1));
    chk("bp_handoff_busy", 128'(busy_v[MAIN]), 128'(0));
    @(posedge clk); #1;
    in_valid_v[MAIN] = 1'b0;
    chk("bp_accept", 128'(busy_v[MAIN]), 128'(1));
    wait_out(MAIN, c);
    chk("bp_second", out_state_v[MAIN], model(1'b0, x2));
    out_ready_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[MAIN] = 1'b0;

    // Abort on BUSY beat 2.
    in_mode = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_valid_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[MAIN] = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", 128'(in_ready_v[MAIN]), 128'(1));
    chk("abort_busy", 128'(busy_v[MAIN]), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | out_valid_v[MAIN];
      @(posedge clk); #1;
    end
    chk("abort_no_valid", 128'(seen), 128'(0));
    run_block(MAIN, 1'b0, '0, y1, lat);
    chk("abort_next_block", y1, 128'h22448811_22448811_22448811_22448811);

    // Abort in IDLE blocks the accept.
    in_valid_v[MAIN] = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    in_valid_v[MAIN] = 1'b0;
    abort = 1'b0;
    chk("abort_idle_no_accept", 128'(busy_v[MAIN]), 128'(0));

    // Abort in DONE together with out_ready.
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_valid_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[MAIN] = 1'b0;
    wait_out(MAIN, c);
    abort = 1'b1;
    out_ready_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready_v[MAIN] = 1'b0;
    chk("abort_done_valid", 128'(out_valid_v[MAIN]), 128'(0));
    chk("abort_done_state", out_state_v[MAIN], 128'(0));

    // Async reset mid-BUSY.
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_valid_v[MAIN] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[MAIN] = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid_v[MAIN]), 128'(0));
    chk("arst_busy", 128'(busy_v[MAIN]), 128'(0));
    chk("arst_out_state", out_state_v[MAIN], 128'(0));
    chk("arst_in_ready", 128'(in_ready_v[MAIN]), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | out_valid_v[MAIN];
      @(posedge clk); #1;
    end
    chk("arst_no_stale_valid", 128'(seen), 128'(0));
    run_block(MAIN, 1'b0, '0, y1, lat);
    chk("arst_next_block", y1, 128'h22448811_22448811_22448811_22448811);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
